// File: rtl/reg_bank_mp.sv
// Multi-read-port register file with registered read data, per-port valid and
// a post-reset clear sequencer. Optional write-to-read forwarding: REGFILE_BYPASS_EN.
module reg_bank_mp #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_valid,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    output logic                busy
);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_clr_cnt;
    logic [AW-1:0]       w_cnt_nxt;
    logic [XLEN-1:0]     r_regs [NREGS];
    logic [NRD*XLEN-1:0] r_rd_data;
    logic [NRD-1:0]      r_rd_valid;

    logic                w_we;
    logic [AW-1:0]       w_wr_idx;
    logic [XLEN-1:0]     w_wr_val;
    logic                w_run_we;
    logic [XLEN-1:0]     w_rd_val [NRD];

    assign w_run_we = (r_state == S_RUN) && wr_en && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_cnt_nxt;
        end
    end

    // The clear sequencer and the user write port share the single array write port.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_clr_cnt;
        w_we        = 1'b0;
        w_wr_idx    = wr_addr;
        w_wr_val    = wr_data;
        case (r_state)
            S_CLEAR: begin
                w_we      = 1'b1;
                w_wr_idx  = r_clr_cnt;
                w_wr_val  = '0;
                w_cnt_nxt = r_clr_cnt + AW'(1);
                if (r_clr_cnt == AW'(NREGS - 1))
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_we = w_run_we;
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_we)
            r_regs[w_wr_idx] <= w_wr_val;
    end

    always_comb begin
        for (int unsigned p = 0; p < NRD; p++) begin
            w_rd_val[p] = '0;
            if (rd_addr[p*AW +: AW] != '0) begin
                w_rd_val[p] = r_regs[rd_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (w_run_we && (wr_addr == rd_addr[p*AW +: AW]))
                    w_rd_val[p] = wr_data;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= '0;
        end else if (r_state == S_RUN) begin
            for (int unsigned p = 0; p < NRD; p++) begin
                r_rd_valid[p] <= rd_en[p];
                if (rd_en[p])
                    r_rd_data[p*XLEN +: XLEN] <= w_rd_val[p];
            end
        end else begin
            r_rd_valid <= '0;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state == S_CLEAR);

endmodule
